// File: rtl/dcp_egress_queue.sv
// Per-output-port egress FIFO behind one decoupled-crossbar output, with destination check.
// Optional saturating statistics counters are enabled by defining DCP_EGRESS_STATS_EN.
module dcp_egress_queue #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6,
  parameter int PORT_ID  = 0
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iInVld,
  input  logic [DW-1:0]                iInPld,
  input  logic [AW-1:0]                iInDst,
  output logic                         oInRdy,
  output logic                         oOutVld,
  output logic [DW-1:0]                oOutPld,
  input  logic                         iOutRdy,
  output logic [$clog2(DEPTH+1)-1:0]   oCount,
  output logic                         oAfull,
  output logic                         oMisroute
`ifdef DCP_EGRESS_STATS_EN
  ,
  output logic [31:0]                  oBeatCnt,
  output logic [15:0]                  oDropCnt,
  output logic [31:0]                  oStallCnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [AW-1:0] PORT_DST  = AW'(PORT_ID);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          afull_q, afull_d;
  logic          misroute_q, misroute_d;
  logic          in_rdy, out_vld, accept, dst_ok, push, pop;

  // Ready depends only on the registered count, never on iOutRdy.
  assign in_rdy  = (count_q < FULL_CNT);
  assign out_vld = (count_q != '0);
  assign accept  = iInVld && in_rdy;
  assign dst_ok  = (iInDst == PORT_DST);
  assign push    = accept && dst_ok;
  assign pop     = out_vld && iOutRdy;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misroute_d = misroute_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    afull_d = (count_d >= AFULL_CNT);
    if (accept && !dst_ok) misroute_d = 1'b1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      afull_q    <= 1'b0;
      misroute_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      afull_q    <= afull_d;
      misroute_q <= misroute_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge iClk) begin
    if (push) mem_q[wr_ptr_q] <= iInPld;
  end

  assign oInRdy    = in_rdy;
  assign oOutVld   = out_vld;
  assign oOutPld   = out_vld ? mem_q[rd_ptr_q] : '0;
  assign oCount    = count_q;
  assign oAfull    = afull_q;
  assign oMisroute = misroute_q;

`ifdef DCP_EGRESS_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // All three counters saturate instead of wrapping.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push && (beat_cnt_q != '1))                 beat_cnt_d  = beat_cnt_q + 32'd1;
    if (accept && !dst_ok && (drop_cnt_q != '1))    drop_cnt_d  = drop_cnt_q + 16'd1;
    if (out_vld && !iOutRdy && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      beat_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oBeatCnt  = beat_cnt_q;
  assign oDropCnt  = drop_cnt_q;
  assign oStallCnt = stall_cnt_q;
`endif

endmodule
